ecp5_pll_phase_ctrl: RTL
========================

// Module: ecp5_pll_phase_ctrl
// PURPOSE
//  Sequencer for the ECP5 EHXPLLL dynamic phase-shift port and lock bring-up. Resets the PLL,
//  qualifies LOCK, then accepts phase-step requests (output select, direction, step count)
//  and drives PHASESEL/PHASEDIR/PHASESTEP with the required setup/pulse/settle timing.
//  Tracks the accumulated phase position of each PLL output. Sits beside the clock wrapper,
//  in the always-on 25 MHz input clock domain.
// PARAMETERS
//  RST_CYC    16   cycles pll_rst held high after reset or abort
//  LOCK_CYC   1024 consecutive cycles pll_locked must be high before ready
//  SETUP_CYC  4    cycles phasesel/phasedir stable before phasestep rises (>=1)
//  STEP_CYC   4    cycles phasestep held high per step (>=1)
//  SETTLE_CYC 8    cycles after phasestep falls before the next step/done (>=1)
//  CNT_W      8    width of step-count request field
//  POS_MOD    80   phase positions per output (8 x VCO/output ratio); position wraps mod this
// PORTS
//  clk             in   1          system clock (PLL input clock domain)
//  resetn          in   1          synchronous reset, active low
//  pll_locked      in   1          EHXPLLL LOCK (async; 2-FF synchronised internally)
//  pll_rst         out  1          EHXPLLL RST
//  pll_phasesel    out  2          EHXPLLL PHASESEL[1:0]: 0 CLKOS,1 CLKOS2,2 CLKOS3,3 CLKOP
//  pll_phasedir    out  1          EHXPLLL PHASEDIR: 1 advance, 0 delay
//  pll_phasestep   out  1          EHXPLLL PHASESTEP
//  req_valid       in   1          phase-shift request valid
//  req_ready       out  1          high only in IDLE
//  req_sel         in   2          output to shift
//  req_dir         in   1          1 advance, 0 delay
//  req_count       in   CNT_W      number of steps; 0 = accepted, completes with no pulse
//  done            out  1          1-cycle pulse when request finishes (or aborts)
//  err             out  1          sticky: lock lost during a request; cleared by next accept
//  ready           out  1          PLL locked and qualified
//  pos             out  4*POS_W    packed positions, [k*POS_W +: POS_W] = output k, POS_W=$clog2(POS_MOD)
// BEHAVIOUR
//  - Reset (resetn=0 at clk edge): state=RST, pll_rst=1, phasestep=0, phasesel=0, phasedir=0,
//    done=0, err=0, ready=0, req_ready=0, all pos=0, counters=0. Reset mid-request aborts silently.
//  - RST: pll_rst=1 for RST_CYC cycles -> WAIT_LOCK (pll_rst=0).
//  - WAIT_LOCK: counts synchronised lock high; any low restarts count; LOCK_CYC reached ->
//    IDLE, ready=1. Lock low is never counted; no timeout.
//  - IDLE: req_ready=1; accept on req_valid&&req_ready: latch sel/dir/count, drive phasesel/
//    phasedir same cycle as entering SETUP, clear err. count=0 -> DONE directly.
//  - SETUP: SETUP_CYC cycles, phasestep=0 -> STEP.
//  - STEP: phasestep=1 for STEP_CYC cycles; on exit pos[sel] += dir?+1:-1 mod POS_MOD
//    (POS_MOD-1 +1 -> 0; 0 -1 -> POS_MOD-1); remaining-- -> SETTLE.
//  - SETTLE: phasestep=0 for SETTLE_CYC; remaining>0 -> STEP (sel/dir unchanged, no new setup),
//    else DONE.
//  - DONE: done=1 one cycle -> IDLE. Back-to-back accept possible the cycle after DONE.
//  - phasesel/phasedir hold last latched value in IDLE; never change while phasestep=1.
//  - Lock loss: synchronised lock low in IDLE or any step state -> ready=0, phasestep=0;
//    if a request was in flight: err=1, done pulse, pos[sel] keeps steps already completed;
//    then -> RST (full PLL re-reset; pos cleared since PLL phase resets).
//  - req_valid ignored when req_ready=0; no queuing.
// STRUCTURE
//  - Package ecp5_pll_pkg: state enum (RST,WAIT_LOCK,IDLE,SETUP,STEP,SETTLE,DONE),
//    PHASESEL encodings for CLKOS/CLKOS2/CLKOS3/CLKOP.
//  - Single FSM with one shared down-counter for RST/LOCK/SETUP/STEP/SETTLE timing,
//    a step-remaining counter, and pos register array.
//  - Sub-module ecp5_pll_phase_pos: one modulo-POS_MOD up/down counter, instanced 4x.
// TESTING
//  - Bring-up: release resetn, PLL model locks 30 cycles after rst falls -> pll_rst high 16
//    cycles, ready rises exactly 1024 cycles after lock synchronised.
//  - Lock glitch at count 500 in WAIT_LOCK -> count restarts; ready after 1024 clean cycles.
//  - Request sel=1,dir=1,count=3 -> 3 phasestep pulses, each 4 high / >=8 low, first rise 4
//    cycles after accept; phasesel=1,phasedir=1 stable throughout; done once; pos[1]=3.
//  - Wrap: sel=3,dir=0,count=2 from pos 0 -> pos[3]=78; then dir=1,count=82 -> pos[3]=0.
//  - count=0 -> no phasestep pulse, done 1 cycle after accept path, pos unchanged.
//  - Drop lock during 2nd of 5 steps -> phasestep low next cycle, err=1, done pulse,
//    pll_rst reasserted, ready=0; after relock, next accept clears err.

Source files
------------

// File: rtl/ecp5_pll_phase_ctrl_pkg.sv
// ecp5_pll_pkg: sequencer states, PHASESEL encodings and a sizing helper
package ecp5_pll_pkg;
  typedef enum logic [2:0] {RST, WAIT_LOCK, IDLE, SETUP, STEP, SETTLE, DONE} state_t;
  localparam logic [1:0] SEL_CLKOS  = 2'd0;
  localparam logic [1:0] SEL_CLKOS2 = 2'd1;
  localparam logic [1:0] SEL_CLKOS3 = 2'd2;
  localparam logic [1:0] SEL_CLKOP  = 2'd3;
  function automatic int max_of(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ecp5_pll_phase_ctrl_if.sv
// ecp5_pll_phase_ctrl_if: phase-step request channel between requester and sequencer
interface ecp5_pll_phase_ctrl_if #(parameter int CNT_W = 8) ();
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_sel;
  logic             req_dir;
  logic [CNT_W-1:0] req_count;
  logic             done;
  logic             err;
  modport master (output req_valid, req_sel, req_dir, req_count, input req_ready, done, err);
  modport slave (input req_valid, req_sel, req_dir, req_count, output req_ready, done, err);
endinterface

// File: rtl/ecp5_pll_phase_ctrl_pos.sv
// ecp5_pll_phase_pos: modulo-POS_MOD up/down phase position counter for one PLL output
module ecp5_pll_phase_pos #(
  parameter int POS_MOD = 80,
  localparam int POS_W = $clog2(POS_MOD)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic             dir,
  output logic [POS_W-1:0] pos
);
  localparam logic [POS_W-1:0] TOP = POS_W'(POS_MOD - 1);
  always_ff @(posedge clk)
    if (!resetn || clr) pos <= '0;
    else if (en) pos <= dir ? (pos == TOP ? '0 : pos + 1'b1) : (pos == '0 ? TOP : pos - 1'b1);
endmodule

// File: rtl/ecp5_pll_phase_ctrl.sv
// ecp5_pll_phase_ctrl: EHXPLLL reset/lock bring-up and dynamic phase-step sequencer
module ecp5_pll_phase_ctrl
  import ecp5_pll_pkg::*;
#(
  parameter int RST_CYC    = 16,
  parameter int LOCK_CYC   = 1024,
  parameter int SETUP_CYC  = 4,
  parameter int STEP_CYC   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int CNT_W      = 8,
  parameter int POS_MOD    = 80,
  localparam int POS_W = $clog2(POS_MOD)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pll_locked,
  output logic                 pll_rst,
  output logic [1:0]           pll_phasesel,
  output logic                 pll_phasedir,
  output logic                 pll_phasestep,
  ecp5_pll_phase_ctrl_if.slave bus,
  output logic                 ready,
  output logic [4*POS_W-1:0]   pos
);
  localparam int TMR_W = $clog2(max_of(max_of(RST_CYC, LOCK_CYC),
                                       max_of(max_of(SETUP_CYC, STEP_CYC), SETTLE_CYC)) + 1);
  state_t           state;
  logic [1:0]       lk;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] lim;
  logic             tdone;
  logic [CNT_W-1:0] rem;
  logic             step_en;
  always_comb begin
    lim = state == RST       ? TMR_W'(RST_CYC - 1)   :
          state == WAIT_LOCK ? TMR_W'(LOCK_CYC - 1)  :
          state == SETUP     ? TMR_W'(SETUP_CYC - 1) :
          state == STEP      ? TMR_W'(STEP_CYC - 1)  : TMR_W'(SETTLE_CYC - 1);
    tdone = tmr == lim;
    step_en = state == STEP && tdone && lk[1];
  end
  always_ff @(posedge clk) begin
    lk <= {lk[0], pll_locked};
    if (!resetn) begin
      lk            <= '0;
      state         <= RST;
      tmr           <= '0;
      rem           <= '0;
      pll_rst       <= 1'b1;
      pll_phasesel  <= '0;
      pll_phasedir  <= 1'b0;
      pll_phasestep <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.req_ready <= 1'b0;
      ready         <= 1'b0;
    end else begin
      tmr      <= tdone ? '0 : tmr + 1'b1;
      bus.done <= 1'b0;
      if (!lk[1] && state inside {IDLE, SETUP, STEP, SETTLE}) begin
        state         <= RST;
        tmr           <= '0;
        pll_rst       <= 1'b1;
        pll_phasestep <= 1'b0;
        ready         <= 1'b0;
        bus.req_ready <= 1'b0;
        if (state != IDLE) begin
          bus.err  <= 1'b1;
          bus.done <= 1'b1;
        end
      end else
        case (state)
          RST: if (tdone) begin
            state   <= WAIT_LOCK;
            pll_rst <= 1'b0;
          end
          WAIT_LOCK: if (!lk[1]) tmr <= '0;
            else if (tdone) begin
              state         <= IDLE;
              ready         <= 1'b1;
              bus.req_ready <= 1'b1;
            end
          IDLE: if (bus.req_valid) begin
            pll_phasesel  <= bus.req_sel;
            pll_phasedir  <= bus.req_dir;
            rem           <= bus.req_count;
            bus.err       <= 1'b0;
            bus.req_ready <= 1'b0;
            tmr           <= '0;
            state         <= bus.req_count == '0 ? DONE : SETUP;
            bus.done      <= bus.req_count == '0;
          end
          SETUP: if (tdone) begin
            state         <= STEP;
            pll_phasestep <= 1'b1;
          end
          STEP: if (tdone) begin
            state         <= SETTLE;
            pll_phasestep <= 1'b0;
            rem           <= rem - 1'b1;
          end
          SETTLE: if (tdone) begin
            state         <= rem != '0 ? STEP : DONE;
            pll_phasestep <= rem != '0;
            bus.done      <= rem == '0;
          end
          DONE: begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end
          default: state <= RST;
        endcase
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_pos
    ecp5_pll_phase_pos #(.POS_MOD(POS_MOD)) u_pos (
      .clk    (clk),
      .resetn (resetn),
      .clr    (state == RST),
      .en     (step_en && pll_phasesel == 2'(i)),
      .dir    (pll_phasedir),
      .pos    (pos[i*POS_W +: POS_W])
    );
  end
endmodule
